// File: rtl/cr_xp10_decomp_fe_crc_ctl_pkg.sv
// Shared definitions for the XP10 decompressor front-end CRC path:
// the frame FSM state encoding, the CRC32C seed and polynomial, and the
// fixed data/size widths.
package cr_xp10_decompPKG;

  localparam int DATA_W = 64;
  localparam int SZ_W   = 7;
  localparam int CRC_W  = 32;

  localparam logic [CRC_W-1:0] CRC_SEED = 32'hFFFF_FFFF;
  // Reflected CRC32C (Castagnoli) polynomial
  localparam logic [CRC_W-1:0] CRC_POLY = 32'h82F6_3B78;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESULT = 2'd2
  } crc_state_e;

  // Folds one byte into a reflected CRC32C register, LSB first
  function automatic logic [CRC_W-1:0] crc32c_byte(input logic [CRC_W-1:0] c_in,
                                                   input logic [7:0]       b);
    logic [CRC_W-1:0] c;
    c = c_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/cr_xp10_decomp_fe_crc.sv
// Combinational CRC32C engine: folds the low sz/8 bytes of a 64-bit beat
// (byte 0 first) into the running value. sof replaces the running value
// with the seed before folding. sz must already be a multiple of 8, <= 64.
module cr_xp10_decomp_fe_crc
  import cr_xp10_decompPKG::*;
(
  input  logic [CRC_W-1:0]  crc_in,
  input  logic              sof,
  input  logic [DATA_W-1:0] data,
  input  logic [SZ_W-1:0]   sz,
  output logic [CRC_W-1:0]  crc_out
);

  // Byte-serial fold over the enabled bytes of the beat
  always_comb begin
    crc_out = sof ? CRC_SEED : crc_in;
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (7'(b * 8) < sz) begin
        crc_out = crc32c_byte(crc_out, data[b*8 +: 8]);
      end
    end
  end

endmodule

// File: rtl/cr_xp10_decomp_fe_crc_ctl.sv
// Frame sequencer around the CRC32C engine: accumulates a running CRC over
// accepted beats, presents the final CRC and mismatch flag for one result
// handshake, and flags framing violations.
// Optional build macro: CR_XP10_DECOMP_FE_CRC_STATS_EN enables the
// saturating frame/error counters; otherwise frm_cnt/err_cnt are tied to 0.
module cr_xp10_decomp_fe_crc_ctl
  import cr_xp10_decompPKG::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SZ_W-1:0]   in_sz,
  input  logic [CRC_W-1:0]  in_exp_crc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CRC_W-1:0]  res_crc,
  output logic              res_err,
  output logic              proto_err,
  output logic [15:0]       frm_cnt,
  output logic [15:0]       err_cnt
);

  crc_state_e       state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] exp_q, exp_d;
  logic             proto_q, proto_d;
  logic [CRC_W-1:0] crc_next;
  logic [SZ_W-1:0]  sz_eff;
  logic             sz_ok;
  logic             eng_sof;
  logic             in_acc;
  logic             res_hs;

  assign in_ready  = (state_q != RESULT);
  assign in_acc    = in_valid & in_ready;
  assign res_valid = (state_q == RESULT);
  assign res_hs    = res_valid & res_ready;
  assign res_crc   = ~crc_q;
  assign res_err   = (~crc_q != exp_q);
  assign proto_err = proto_q;

  // Illegal sizes are treated as a full beat
  assign sz_ok   = (in_sz[2:0] == 3'd0) && (in_sz <= 7'd64);
  assign sz_eff  = sz_ok ? in_sz : 7'd64;
  // Any beat arriving in IDLE starts a frame, whether or not sof is set
  assign eng_sof = in_sof | (state_q == IDLE);

  cr_xp10_decomp_fe_crc u_crc (
    .crc_in  (crc_q),
    .sof     (eng_sof),
    .data    (in_data),
    .sz      (sz_eff),
    .crc_out (crc_next)
  );

  // Next-state, running CRC, expected-CRC capture and framing checks
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    exp_d   = exp_q;
    proto_d = 1'b0;
    if (in_acc) begin
      crc_d   = crc_next;
      proto_d = !sz_ok
              | ((state_q == IDLE)   & !in_sof)
              | ((state_q == ACTIVE) &  in_sof);
      if (in_eof) begin
        exp_d   = in_exp_crc;
        state_d = RESULT;
      end else begin
        state_d = ACTIVE;
      end
    end else if (res_hs) begin
      state_d = IDLE;
    end
  end

  // Control and datapath state; reset drops any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      crc_q   <= CRC_SEED;
      exp_q   <= '0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      exp_q   <= exp_d;
      proto_q <= proto_d;
    end
  end

`ifdef CR_XP10_DECOMP_FE_CRC_STATS_EN
  logic [15:0] frm_cnt_q, frm_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating statistics, counted on each result handshake
  always_comb begin
    frm_cnt_d = frm_cnt_q;
    err_cnt_d = err_cnt_q;
    if (res_hs) begin
      if (frm_cnt_q != 16'hFFFF) frm_cnt_d = frm_cnt_q + 16'd1;
      if (res_err && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      frm_cnt_q <= frm_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign frm_cnt = frm_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  assign frm_cnt = 16'd0;
  assign err_cnt = 16'd0;
`endif

endmodule
